dsram_axi_bridge: RTL

Converts the CPU's data-side SRAM-like port into single-beat AXI3 master read and write transactions. It drives data_stall back to the CPU while a transaction is outstanding. It uses longest_stall so that each pipeline stall period issues exactly one memory access. It sits directly downstream of the CPU top's data_sram_* outputs, used for uncached (no_dcache) traffic and for the cache-less build.

---
 rtl/dsram_axi_bridge.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dsram_axi_bridge.sv
// Bridges the CPU data-side SRAM-like port onto single-beat AXI3 read/write transactions.
// One memory access is issued per pipeline stall period, gated by longest_stall.
module dsram_axi_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_stall,
    input  logic        longest_stall,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B} state_t;

    state_t state, state_next;
    logic   done;
    logic   aw_done, w_done;
    logic   launch, rd_hs, b_hs, aw_hs, w_hs;
    logic   aw_complete, w_complete;
    logic   unused_rlast;

    function automatic logic [2:0] size_from_strb(input logic [3:0] strb);
        case (strb)
            4'b1111:                            return 3'd2;
            4'b1100, 4'b0011:                   return 3'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 3'd0;
            default:                            return 3'd2;
        endcase
    endfunction

    assign unused_rlast = rlast;
    assign arsize       = 3'd2;
    assign wlast        = 1'b1;

    assign data_stall  = data_sram_en & ~done;
    assign launch      = (state == IDLE) & data_sram_en & ~done;
    assign rd_hs       = rvalid & rready;
    assign b_hs        = bvalid & bready;
    assign aw_hs       = awvalid & awready;
    assign w_hs        = wvalid & wready;
    assign aw_complete = aw_done | aw_hs;
    assign w_complete  = w_done | w_hs;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = (data_sram_wen == 4'b0000) ? RD_AR : WR_AW_W;
            RD_AR:   if (arready) state_next = RD_R;
            RD_R:    if (rd_hs) state_next = IDLE;
            WR_AW_W: if (aw_complete && w_complete) state_next = WR_B;
            WR_B:    if (b_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // AW and W valids are Moore outputs masked by their own completion flags,
    // so each channel drops independently the cycle after its handshake.
    always_comb begin
        arvalid = (state == RD_AR);
        rready  = (state == RD_R);
        awvalid = (state == WR_AW_W) & ~aw_done;
        wvalid  = (state == WR_AW_W) & ~w_done;
        bready  = (state == WR_B);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state != WR_AW_W) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // done holds off relaunch until the pipeline-wide stall period ends.
    always_ff @(posedge clk) begin
        if (rst)                 done <= 1'b0;
        else if (rd_hs || b_hs)  done <= 1'b1;
        else if (!longest_stall) done <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            araddr          <= '0;
            awaddr          <= '0;
            wdata           <= '0;
            wstrb           <= '0;
            awsize          <= '0;
            data_sram_rdata <= '0;
        end else begin
            if (launch && data_sram_wen == 4'b0000) begin
                araddr <= data_sram_addr;
            end
            if (launch && data_sram_wen != 4'b0000) begin
                awaddr <= data_sram_addr;
                wdata  <= data_sram_wdata;
                wstrb  <= data_sram_wen;
                awsize <= size_from_strb(data_sram_wen);
            end
            if (rd_hs) data_sram_rdata <= rdata;
        end
    end

endmodule
